// File: rtl/memio_pkg.sv
// Shared types and constants for the load/store sequencer and its lane aligner.
package memio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAM_RD,
        ST_IO_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Upper 22 address bits of the memory-mapped IO window 0xFFFFFC00-0xFFFFFFFF.
    localparam logic [21:0] IO_BASE = 22'h3FFFFF;

    function automatic size_t size_of(logic [2:0] funct3);
        case (funct3)
            LB, LBU: return SZ_B;
            LH, LHU: return SZ_H;
            LW:      return SZ_W;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/ls_align.sv
// Store lane replication / byte enables and load byte selection / extension,
// shared by the RAM and IO paths of mem_io_sequencer.
module ls_align
    import memio_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_lanes_o,
    output logic        st_misaligned_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    size_t       st_size;
    size_t       ld_size;
    logic        ld_signed;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign st_size = size_of(st_funct3_i);
    assign ld_size = size_of(ld_funct3_i);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        st_be_o         = 4'b1111;
        st_lanes_o      = st_data_i;
        st_misaligned_o = 1'b0;
        case (st_size)
            SZ_B: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_lanes_o = {4{st_data_i[7:0]}};
            end
            SZ_H: begin
                st_be_o         = 4'b0011 << {st_off_i[1], 1'b0};
                st_lanes_o      = {2{st_data_i[15:0]}};
                st_misaligned_o = st_off_i[0];
            end
            default: st_misaligned_o = (st_off_i != 2'b00);
        endcase
    end

    // funct3[2] set means the unsigned variants (bu/hu).
    assign ld_signed = ~ld_funct3_i[2];
    assign ld_byte   = ld_word_i[{ld_off_i, 3'b000} +: 8];
    assign ld_half   = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    always_comb begin
        ld_data_o = ld_word_i;
        case (ld_size)
            SZ_B:    ld_data_o = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data_o = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/mem_io_sequencer.sv
// Multi-cycle load/store sequencer between the core's execute stage, the
// synchronous word RAM and the memory-mapped IO request/acknowledge bus.
module mem_io_sequencer
    import memio_pkg::*;
#(
    parameter int RAM_AW     = 14,
    parameter int IO_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              io_read,
    input  logic              io_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              misalign_err,
    output logic              io_timeout_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_req,
    output logic              io_we,
    output logic [9:0]        io_addr,
    output logic [31:0]       io_wdata,
    output logic [3:0]        io_be,
    input  logic [31:0]       io_rdata,
    input  logic              io_ack
);

    localparam int              CNT_W    = $clog2(IO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [31:0]       rdata_q,    rdata_d;
    logic              is_read_q,  is_read_d;
    logic [2:0]        funct3_q,   funct3_d;
    logic [1:0]        off_q,      off_d;
    logic              io_req_q,   io_req_d;
    logic              io_we_q,    io_we_d;
    logic [9:0]        io_addr_q,  io_addr_d;
    logic [31:0]       io_wdata_q, io_wdata_d;
    logic [3:0]        io_be_q,    io_be_d;
    logic              tmo_q,      tmo_d;

    logic [3:0]  st_be;
    logic [31:0] st_lanes;
    logic        st_misaligned;
    logic [31:0] ld_word;
    logic [31:0] ld_data;
    logic        any_req;
    logic        unused_addr_hi;

    // Decoding is done upstream; the high address bits only matter there.
    assign unused_addr_hi = ^{addr[31:RAM_AW+2], (addr[31:10] == IO_BASE)};

    assign ld_word = (state_q == ST_RAM_RD) ? ram_rdata : io_rdata;

    ls_align u_align (
        .st_funct3_i     (funct3),
        .st_off_i        (addr[1:0]),
        .st_data_i       (wdata),
        .st_be_o         (st_be),
        .st_lanes_o      (st_lanes),
        .st_misaligned_o (st_misaligned),
        .ld_funct3_i     (funct3_q),
        .ld_off_i        (off_q),
        .ld_word_i       (ld_word),
        .ld_data_o       (ld_data)
    );

    // Gating with rst_n keeps the combinational strobes quiet while reset is held.
    assign any_req = rst_n & (mem_read | mem_write | io_read | io_write);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        is_read_d    = is_read_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        io_req_d     = io_req_q;
        io_we_d      = io_we_q;
        io_addr_d    = io_addr_q;
        io_wdata_d   = io_wdata_q;
        io_be_d      = io_be_q;
        tmo_d        = 1'b0;
        stall        = 1'b0;
        done         = 1'b0;
        misalign_err = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 4'b0000;
        ram_addr     = '0;
        ram_wdata    = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    if (st_misaligned) begin
                        misalign_err = 1'b1;
                    end else if (mem_write) begin
                        ram_en    = 1'b1;
                        ram_we    = st_be;
                        ram_addr  = addr[RAM_AW+1:2];
                        ram_wdata = st_lanes;
                    end else begin
                        stall     = 1'b1;
                        is_read_d = mem_read | io_read;
                        funct3_d  = funct3;
                        off_d     = addr[1:0];
                        if (mem_read) begin
                            ram_en   = 1'b1;
                            ram_addr = addr[RAM_AW+1:2];
                            state_d  = ST_RAM_RD;
                        end else begin
                            cnt_d      = '0;
                            io_req_d   = 1'b1;
                            io_we_d    = io_write;
                            io_addr_d  = addr[9:0];
                            io_wdata_d = st_lanes;
                            io_be_d    = st_be;
                            state_d    = ST_IO_WAIT;
                        end
                    end
                end
            end
            ST_RAM_RD: begin
                stall   = 1'b1;
                rdata_d = ld_data;
                state_d = ST_DONE;
            end
            ST_IO_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                // An ack in the timeout cycle still wins over the timeout.
                if (io_ack) begin
                    io_req_d = 1'b0;
                    if (is_read_q) begin
                        rdata_d = ld_data;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    io_req_d = 1'b0;
                    rdata_d  = '0;
                    tmo_d    = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = is_read_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            is_read_q  <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            io_req_q   <= 1'b0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            io_be_q    <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            is_read_q  <= is_read_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            io_req_q   <= io_req_d;
            io_we_q    <= io_we_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            io_be_q    <= io_be_d;
            tmo_q      <= tmo_d;
        end
    end

    assign rdata          = rdata_q;
    assign io_timeout_err = tmo_q;
    assign io_req         = io_req_q;
    assign io_we          = io_we_q;
    assign io_addr        = io_addr_q;
    assign io_wdata       = io_wdata_q;
    assign io_be          = io_be_q;

endmodule

// File: tb/tb_mem_io_sequencer.sv
// Self-checking bench for mem_io_sequencer: directed test-plan scenarios plus
// randomized traffic against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_mem_io_sequencer;

    localparam int RAM_AW = 14;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_read, mem_write, io_read, io_write;
    logic [2:0]        funct3;
    logic [31:0]       addr, wdata;
    logic              stall, done, misalign_err, io_timeout_err;
    logic [31:0]       rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;
    logic              io_req, io_we, io_ack;
    logic [9:0]        io_addr;
    logic [31:0]       io_wdata, io_rdata;
    logic [3:0]        io_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_io_sequencer #(.RAM_AW(RAM_AW), .IO_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .io_read(io_read), .io_write(io_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .done(done),
        .misalign_err(misalign_err), .io_timeout_err(io_timeout_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_be(io_be),
        .io_rdata(io_rdata), .io_ack(io_ack)
    );

    // Synchronous word RAM with one-cycle read latency (read-before-write).
    logic [31:0] ram_model [0:(1<<RAM_AW)-1];
    logic [31:0] ram_merge;
    always @(posedge clk) begin
        if (ram_en) begin
            ram_merge = ram_model[ram_addr];
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) ram_merge[8*i +: 8] = ram_wdata[8*i +: 8];
            ram_rdata <= ram_model[ram_addr];
            ram_model[ram_addr] <= ram_merge;
        end
    end

    // Reference model: a plain byte-addressed memory and arithmetic on access sizes.
    bit [7:0] ref_mem [int unsigned];
    logic [2:0] ld_f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    function automatic int nbytes(logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_misaligned(logic [31:0] a, logic [2:0] f3);
        return (int'(a[1:0]) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(logic [31:0] a, logic [2:0] f3);
        logic [3:0] be = '0;
        int off = int'(a[1:0]);
        for (int k = 0; k < nbytes(f3); k++) be[off + k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_lanes(logic [31:0] d, logic [2:0] f3);
        logic [31:0] w;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] extend(logic [31:0] v, int n, bit sgn);
        logic [31:0] mask;
        logic [31:0] r;
        if (n == 4) return v;
        mask = (32'h1 << (8*n)) - 32'h1;
        r = v & mask;
        if (sgn && r[8*n-1]) r = r | ~mask;
        return r;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] f3);
        logic [31:0] v = '0;
        for (int k = 0; k < nbytes(f3); k++) begin
            int unsigned ba = a + k;
            v = v | (32'(ref_mem.exists(ba) ? ref_mem[ba] : 8'h00) << (8*k));
        end
        return extend(v, nbytes(f3), !f3[2]);
    endfunction

    function automatic logic [31:0] io_expect(logic [31:0] word, logic [31:0] a, logic [2:0] f3);
        return extend(word >> (8*int'(a[1:0])), nbytes(f3), !f3[2]);
    endfunction

    task automatic set_op(input logic mr, mw, ir, iw, input logic [31:0] a, d, input logic [2:0] f3);
        mem_read = mr; mem_write = mw; io_read = ir; io_write = iw;
        addr = a; wdata = d; funct3 = f3;
    endtask

    task automatic do_store(input logic [31:0] a, d, input logic [2:0] f3);
        @(negedge clk);
        set_op(0, 1, 0, 0, a, d, f3);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_stall a=%h got %b want 0", a, stall); end
        checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL store_en a=%h got %b want 1", a, ram_en); end
        checks++; if (ram_we !== exp_be(a, f3)) begin errors++; $display("FAIL store_we a=%h got %b want %b", a, ram_we, exp_be(a, f3)); end
        checks++; if (ram_addr !== a[RAM_AW+1:2]) begin errors++; $display("FAIL store_addr a=%h got %h want %h", a, ram_addr, a[RAM_AW+1:2]); end
        checks++; if (ram_wdata !== exp_lanes(d, f3)) begin errors++; $display("FAIL store_wdata a=%h got %h want %h", a, ram_wdata, exp_lanes(d, f3)); end
        for (int k = 0; k < nbytes(f3); k++) ref_mem[a + k] = d[8*k +: 8];
    endtask

    task automatic do_ram_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] want;
        want = ref_load(a, f3);
        @(negedge clk);
        set_op(1, 0, 0, 0, a, 32'h0, f3);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_stall1 a=%h got %b want 1", a, stall); end
        checks++; if ({ram_en, ram_we} !== 5'b1_0000) begin errors++; $display("FAIL load_en_we a=%h got %b want 10000", a, {ram_en, ram_we}); end
        checks++; if (ram_addr !== a[RAM_AW+1:2]) begin errors++; $display("FAIL load_addr a=%h got %h want %h", a, ram_addr, a[RAM_AW+1:2]); end
        @(negedge clk); #1;
        checks++; if ({stall, done} !== 2'b10) begin errors++; $display("FAIL load_stall2 a=%h got %b want 10", a, {stall, done}); end
        @(negedge clk); #1;
        checks++; if ({stall, done} !== 2'b01) begin errors++; $display("FAIL load_done a=%h got %b want 01", a, {stall, done}); end
        checks++; if (rdata !== want) begin errors++; $display("FAIL load_rdata a=%h f3=%0d got %h want %h", a, f3, rdata, want); end
    endtask

    // ack_at: IO_WAIT cycle (1-based) in which the device acks; 0 means never.
    task automatic do_io(input logic [31:0] a, d, input logic [2:0] f3, input bit wr,
                         input int ack_at, input logic [31:0] ack_word);
        bit tmo_exp = (ack_at == 0) || (ack_at > TMO);
        int last    = tmo_exp ? TMO : ack_at;
        logic [31:0] want;
        want = tmo_exp ? 32'h0 : io_expect(ack_word, a, f3);
        @(negedge clk);
        set_op(0, 0, !wr, wr, a, d, f3);
        io_rdata = $urandom;
        #1;
        checks++; if ({stall, io_req, ram_en} !== 3'b100) begin errors++; $display("FAIL io_setup a=%h got %b want 100", a, {stall, io_req, ram_en}); end
        for (int k = 1; k <= last; k++) begin
            @(negedge clk); #1;
            checks++; if ({io_req, stall} !== 2'b11) begin errors++; $display("FAIL io_wait_req c=%0d got %b want 11", k, {io_req, stall}); end
            if (k == 1) begin
                checks++; if (io_addr !== a[9:0]) begin errors++; $display("FAIL io_addr got %h want %h", io_addr, a[9:0]); end
                checks++; if ({io_we, io_be} !== {wr, exp_be(a, f3)}) begin errors++; $display("FAIL io_we_be got %b want %b", {io_we, io_be}, {wr, exp_be(a, f3)}); end
                if (wr) begin
                    checks++; if (io_wdata !== exp_lanes(d, f3)) begin errors++; $display("FAIL io_wdata got %h want %h", io_wdata, exp_lanes(d, f3)); end
                end
            end
            if (k == ack_at) begin
                io_ack = 1'b1;
                io_rdata = ack_word;
            end
        end
        @(negedge clk);
        io_ack = 1'b0;
        io_rdata = $urandom;
        #1;
        checks++; if ({io_req, stall} !== 2'b00) begin errors++; $display("FAIL io_release got %b want 00", {io_req, stall}); end
        checks++; if ({done, io_timeout_err} !== {!wr, tmo_exp}) begin errors++; $display("FAIL io_done_tmo got %b want %b", {done, io_timeout_err}, {!wr, tmo_exp}); end
        if (!wr) begin
            checks++; if (rdata !== want) begin errors++; $display("FAIL io_rdata a=%h got %h want %h", a, rdata, want); end
        end
    endtask

    task automatic do_misalign(input logic [31:0] a, input logic [2:0] f3, input int which);
        @(negedge clk);
        set_op(which == 0, which == 1, which == 2, which == 3, a, 32'hDEADBEEF, f3);
        #1;
        checks++; if ({misalign_err, ram_en, stall} !== 3'b100) begin errors++; $display("FAIL misalign a=%h f3=%0d got %b want 100", a, f3, {misalign_err, ram_en, stall}); end
        @(negedge clk);
        set_op(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        #1;
        checks++; if ({misalign_err, io_req, stall, done} !== 4'b0000) begin errors++; $display("FAIL misalign_after a=%h got %b want 0000", a, {misalign_err, io_req, stall, done}); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_op(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        io_ack = 1'b0;
        io_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({stall, done, misalign_err, io_timeout_err, ram_en, io_req, io_we} !== 7'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0", {stall, done, misalign_err, io_timeout_err, ram_en, io_req, io_we}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if ({ram_we, ram_addr, ram_wdata} !== '0) begin errors++; $display("FAIL reset_ram got %h want 0", {ram_we, ram_addr, ram_wdata}); end
        checks++; if ({io_addr, io_wdata, io_be} !== '0) begin errors++; $display("FAIL reset_io got %h want 0", {io_addr, io_wdata, io_be}); end
        rst_n = 1'b1;
    endtask

    task automatic test_ram_word();
        do_store(32'h100, 32'h12345678, 3'b010);
        do_ram_load(32'h100, 3'b010);
    endtask

    task automatic test_ram_byte();
        do_store(32'h103, 32'h00000080, 3'b000);
        do_ram_load(32'h103, 3'b000);
        do_ram_load(32'h103, 3'b100);
    endtask

    task automatic test_back_to_back();
        do_store(32'h142, 32'h0000F00D, 3'b001);
        do_ram_load(32'h142, 3'b001);
        do_ram_load(32'h142, 3'b101);
        do_store(32'h141, 32'h000000A5, 3'b000);
        do_ram_load(32'h140, 3'b010);
    endtask

    task automatic test_io();
        do_io(32'hFFFFFC10, 32'h0, 3'b010, 1'b0, 3, 32'h0000ABCD);
        do_io(32'hFFFFFC20, 32'h0, 3'b010, 1'b0, 0, 32'h0);
        do_io(32'hFFFFFC33, 32'h0, 3'b000, 1'b0, TMO, 32'h9A000000);
        do_io(32'hFFFFFC42, 32'hCAFE1234, 3'b001, 1'b1, 1, 32'h0);
    endtask

    task automatic test_misalign();
        do_misalign(32'h101, 3'b001, 0);
        do_misalign(32'h102, 3'b010, 1);
        do_misalign(32'hFFFFFC03, 3'b101, 2);
        do_misalign(32'hFFFFFC01, 3'b010, 3);
    endtask

    task automatic test_reset_mid_io();
        @(negedge clk);
        set_op(0, 0, 1, 0, 32'hFFFFFC20, 32'h0, 3'b010);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (io_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b want 1", io_req); end
        rst_n = 1'b0;
        #1;
        checks++; if ({io_req, stall, done} !== 3'b000) begin errors++; $display("FAIL rst_mid_now got %b want 000", {io_req, stall, done}); end
        @(negedge clk);
        set_op(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if ({io_req, stall, done, rdata} !== '0) begin errors++; $display("FAIL rst_mid_after got %h want 0", {io_req, stall, done, rdata}); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            int kind = $urandom_range(0, 4);
            logic [2:0] f3;
            logic [31:0] a;
            if (kind == 0 || kind == 3) f3 = 3'($urandom_range(0, 2));
            else f3 = ld_f3s[$urandom_range(0, 4)];
            if (kind <= 1) a = 32'h200 + 32'($urandom_range(0, 63));
            else a = 32'hFFFFFC00 | 32'($urandom_range(0, 1023));
            if (kind != 4) a = a & ~32'(nbytes(f3) - 1);
            case (kind)
                0: do_store(a, $urandom, f3);
                1: do_ram_load(a, f3);
                2: do_io(a, 32'h0, f3, 1'b0, $urandom_range(0, TMO + 1), $urandom);
                3: do_io(a, $urandom, f3, 1'b1, $urandom_range(0, TMO + 1), 32'h0);
                default: begin
                    f3 = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
                    a = {a[31:2], 2'b01} | 32'(($urandom_range(0, 1) == 1) ? 2 : 0);
                    if (is_misaligned(a, f3)) do_misalign(a, f3, $urandom_range(0, 3));
                end
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << RAM_AW); i++) ram_model[i] = '0;
        test_reset();
        test_ram_word();
        test_ram_byte();
        test_back_to_back();
        test_io();
        test_misalign();
        test_reset_mid_io();
        test_random();
        @(negedge clk);
        set_op(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
